// File: rtl/grad_pkt_pkg.sv
// Shared definitions for the gradient stream packetizer.
//   WORD_W / WORDS_PER_LINE : word width and words per 512-bit line
//   state_t                 : framer FSM states
//   line_count(n)           : lines needed for a batch of n words plus header
package grad_pkt_pkg;

    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = 16;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    // ceil((n+1)/16) evaluated in 33 bits so n = 2^32-1 cannot wrap.
    function automatic logic [32:0] line_count(input logic [31:0] n);
        logic [32:0] total;
        total = {1'b0, n} + 33'd16;
        return total >> 4;
    endfunction

endpackage

// File: rtl/grad_axis_out_reg.sv
// AXI-stream style output holding register.
//   load / load_pl : capture a new payload (caller guarantees !valid || ready)
//   valid / ready  : stream handshake; payload held stable while valid && !ready
//   pl             : registered payload (data plus any sideband bits)
module grad_axis_out_reg #(
    parameter int PL_W = 513
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [PL_W-1:0] load_pl,
    input  logic            ready,
    output logic            valid,
    output logic [PL_W-1:0] pl
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pl    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            pl    <= load_pl;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/grad_packetizer.sv
// Gradient stream transmit framer: packs header N plus N 32-bit gradient words
// into 512-bit lines, last line zero-padded and flagged with TLAST.
//   cmd_*     : batch command (N) in
//   in_*      : gradient words in
//   tx_data_* : 512-bit lines out (TKEEP only when GRAD_PKT_TKEEP_EN is defined)
//   busy      : batch in flight or line pending
//   pkt_done  : one-cycle pulse after the last-line handshake
// Optional macro: GRAD_PKT_TKEEP_EN adds tx_data_TKEEP byte enables.
module grad_packetizer
    import grad_pkt_pkg::*;
#(
    parameter int DATA_W = 512,
    parameter int WORD_W = grad_pkt_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_TVALID,
    output logic              cmd_TREADY,
    input  logic [WORD_W-1:0] cmd_TDATA,
    input  logic              in_TVALID,
    output logic              in_TREADY,
    input  logic [WORD_W-1:0] in_TDATA,
    output logic              tx_data_TVALID,
    input  logic              tx_data_TREADY,
    output logic [DATA_W-1:0] tx_data_TDATA,
    output logic              tx_data_TLAST,
    output logic              busy,
    output logic              pkt_done
`ifdef GRAD_PKT_TKEEP_EN
    ,
    output logic [DATA_W/8-1:0] tx_data_TKEEP
`endif
);

    localparam int WPL   = DATA_W / WORD_W;
    localparam int IDX_W = $clog2(WPL);
    localparam int BPW   = WORD_W / 8;
`ifdef GRAD_PKT_TKEEP_EN
    localparam int PL_W  = DATA_W + 1 + DATA_W / 8;
`else
    localparam int PL_W  = DATA_W + 1;
`endif

    state_t                       state, state_nxt;
    logic [WPL-1:0][WORD_W-1:0]   pack_reg, line_words;
    logic [IDX_W-1:0]             idx;
    logic [WORD_W-1:0]            words_left;
    logic                         cmd_hs, in_hs, out_hs, last_word, line_done;
    logic                         out_load, load_last;
    logic [DATA_W-1:0]            load_data;
    logic [PL_W-1:0]              load_pl, out_pl;

    assign cmd_TREADY = (state == IDLE) && !tx_data_TVALID;
    assign in_TREADY  = (state == FILL) && (!tx_data_TVALID || tx_data_TREADY);
    assign cmd_hs     = cmd_TVALID && cmd_TREADY;
    assign in_hs      = in_TVALID && in_TREADY;
    assign out_hs     = tx_data_TVALID && tx_data_TREADY;
    assign last_word  = (words_left == WORD_W'(1));
    assign line_done  = in_hs && ((idx == IDX_W'(WPL - 1)) || last_word);
    // N==0 is a header-only line and goes straight to the output register.
    assign out_load   = (cmd_hs && (cmd_TDATA == '0)) || line_done;
    assign load_last  = cmd_hs || last_word;
    assign busy       = (state != IDLE) || tx_data_TVALID;

    // Current line with the accepted word merged into its slot; slots past idx
    // are still zero because pack_reg is cleared at each line start.
    for (genvar s = 0; s < WPL; s++) begin : g_slot
        assign line_words[s] = (in_hs && (idx == IDX_W'(s))) ? in_TDATA : pack_reg[s];
    end

    assign load_data = cmd_hs ? DATA_W'(cmd_TDATA) : line_words;

`ifdef GRAD_PKT_TKEEP_EN
    logic [WPL-1:0]      slot_keep;
    logic [DATA_W/8-1:0] load_keep;
    // Every line starts at slot 0, so the filled slots are 0..idx.
    for (genvar s = 0; s < WPL; s++) begin : g_keep
        if (s == 0) begin : g_first
            assign slot_keep[s] = 1'b1;
        end else begin : g_rest
            assign slot_keep[s] = !cmd_hs && (idx >= IDX_W'(s));
        end
        assign load_keep[s*BPW +: BPW] = {BPW{slot_keep[s]}};
    end
    assign load_pl = {load_keep, load_last, load_data};
    assign {tx_data_TKEEP, tx_data_TLAST, tx_data_TDATA} = out_pl;
`else
    assign load_pl = {load_last, load_data};
    assign {tx_data_TLAST, tx_data_TDATA} = out_pl;
`endif

    grad_axis_out_reg #(.PL_W(PL_W)) u_out (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (out_load),
        .load_pl (load_pl),
        .ready   (tx_data_TREADY),
        .valid   (tx_data_TVALID),
        .pl      (out_pl)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_hs) state_nxt = (cmd_TDATA == '0) ? DRAIN : FILL;
            FILL:    if (line_done && last_word) state_nxt = DRAIN;
            DRAIN:   if (out_hs && tx_data_TLAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pack_reg   <= '0;
            idx        <= '0;
            words_left <= '0;
            pkt_done   <= 1'b0;
        end else begin
            state    <= state_nxt;
            pkt_done <= (state == DRAIN) && out_hs && tx_data_TLAST;
            if (cmd_hs) begin
                pack_reg   <= {{((WPL - 1) * WORD_W){1'b0}}, cmd_TDATA};
                words_left <= cmd_TDATA;
                idx        <= (cmd_TDATA == '0) ? IDX_W'(0) : IDX_W'(1);
            end else if (in_hs) begin
                words_left <= words_left - WORD_W'(1);
                if (line_done) begin
                    pack_reg <= '0;
                    idx      <= '0;
                end else begin
                    pack_reg <= line_words;
                    idx      <= idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_grad_packetizer.sv
module tb_grad_packetizer;
    import grad_pkt_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_TVALID = 1'b0, cmd_TREADY;
    logic [31:0]  cmd_TDATA = '0;
    logic         in_TVALID = 1'b0, in_TREADY;
    logic [31:0]  in_TDATA = '0;
    logic         tx_data_TVALID, tx_data_TREADY = 1'b0;
    logic [511:0] tx_data_TDATA;
    logic         tx_data_TLAST, busy, pkt_done;
`ifdef GRAD_PKT_TKEEP_EN
    logic [63:0]  tx_data_TKEEP;
    logic [63:0]  exp_keep[$];
`endif

    grad_packetizer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_TVALID(cmd_TVALID), .cmd_TREADY(cmd_TREADY), .cmd_TDATA(cmd_TDATA),
        .in_TVALID(in_TVALID), .in_TREADY(in_TREADY), .in_TDATA(in_TDATA),
        .tx_data_TVALID(tx_data_TVALID), .tx_data_TREADY(tx_data_TREADY),
        .tx_data_TDATA(tx_data_TDATA), .tx_data_TLAST(tx_data_TLAST),
        .busy(busy), .pkt_done(pkt_done)
`ifdef GRAD_PKT_TKEEP_EN
        , .tx_data_TKEEP(tx_data_TKEEP)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0]  gw[$];
    logic [511:0] exp_data[$];
    logic         exp_last[$];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference framing: flat stream {N, gw...} cut into 16-word lines.
    task automatic build_expected(input logic [31:0] n);
        int total, lines, i;
        logic [511:0] d;
        logic [63:0]  k;
        exp_data.delete(); exp_last.delete();
`ifdef GRAD_PKT_TKEEP_EN
        exp_keep.delete();
`endif
        total = int'(n) + 1;
        lines = (total + 15) / 16;
        for (int l = 0; l < lines; l++) begin
            d = '0; k = '0;
            for (int s = 0; s < 16; s++) begin
                i = l * 16 + s;
                if (i < total) begin
                    d[s*32 +: 32] = (i == 0) ? n : gw[i-1];
                    k[s*4 +: 4]   = 4'hF;
                end
            end
            exp_data.push_back(d);
            exp_last.push_back(l == lines - 1);
`ifdef GRAD_PKT_TKEEP_EN
            exp_keep.push_back(k);
`endif
        end
    endtask

    // mode 0: always ready, 1 word/cycle; 1: random valid/ready; 2: TREADY low 5 cycles on first line
    task automatic run_batch(input string name, input int n, input int mode);
        int ptr = 0, lines_seen = 0, acc = 1, stall_cnt = 0, cyc = 0;
        bit done = 0, stalled = 0, expect_vld = 0, expect_done = 0;
        bit ihs, ohs;
        logic [511:0] hold_d;
        logic hold_l;
        build_expected(32'(n));
        @(negedge clk);
        cmd_TVALID = 1'b1; cmd_TDATA = 32'(n);
        #1 chk({name, ".cmd_ready"}, cmd_TREADY, 1'b1);
        @(posedge clk);
        if (n == 0) expect_vld = 1;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (expect_vld) chk({name, ".latency"}, tx_data_TVALID, 1'b1);
            expect_vld = 0;
            if (stalled) begin
                chk({name, ".hold_data"}, tx_data_TDATA, hold_d);
                chk({name, ".hold_last"}, tx_data_TLAST, hold_l);
            end
            if (expect_done) begin
                chk({name, ".pkt_done"}, pkt_done, 1'b1);
                chk({name, ".busy_end"}, busy, 1'b0);
                done = 1;
            end else begin
                chk({name, ".busy"}, busy, 1'b1);
                cmd_TVALID = 1'b0;
                in_TVALID = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                in_TDATA  = (ptr < n) ? gw[ptr] : 32'hDEAD0000 + 32'(ptr);
                if (mode == 1) tx_data_TREADY = ($urandom_range(0, 3) != 0);
                else if (mode == 2 && tx_data_TVALID && stall_cnt < 5) begin
                    tx_data_TREADY = 1'b0; stall_cnt++;
                end else tx_data_TREADY = 1'b1;
                #1;
                if (ptr == n) chk({name, ".in_ready_drain"}, in_TREADY, 1'b0);
                ihs = in_TVALID && in_TREADY;
                ohs = tx_data_TVALID && tx_data_TREADY;
                if (ihs) begin
                    ptr++; acc++;
                    if (acc % 16 == 0 || ptr == n) expect_vld = 1;
                end
                if (ohs) begin
                    if (lines_seen < exp_data.size()) begin
                        chk({name, ".tdata"}, tx_data_TDATA, exp_data[lines_seen]);
                        chk({name, ".tlast"}, tx_data_TLAST, exp_last[lines_seen]);
`ifdef GRAD_PKT_TKEEP_EN
                        chk({name, ".tkeep"}, tx_data_TKEEP, exp_keep[lines_seen]);
`endif
                        if (exp_last[lines_seen]) expect_done = 1;
                    end
                    lines_seen++;
                end
                stalled = tx_data_TVALID && !tx_data_TREADY;
                hold_d = tx_data_TDATA; hold_l = tx_data_TLAST;
            end
        end
        in_TVALID = 1'b0; tx_data_TREADY = 1'b0;
        chk({name, ".finished"}, done, 1'b1);
        chk({name, ".lines"}, lines_seen, (n + 16) / 16);
        chk({name, ".words"}, ptr, n);
        if (mode == 0) chk({name, ".throughput"}, cyc, n + 2);
        @(negedge clk);
        chk({name, ".pulse_1cyc"}, pkt_done, 1'b0);
    endtask

    initial begin
        int p;
        #12;
        chk("rst.tvalid", tx_data_TVALID, 1'b0);
        chk("rst.tdata", tx_data_TDATA, '0);
        chk("rst.tlast", tx_data_TLAST, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.pkt_done", pkt_done, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        gw.delete();
        run_batch("n0", 0, 0);
        gw.delete(); for (int i = 1; i <= 15; i++) gw.push_back(32'(i));
        run_batch("n15", 15, 0);
        gw.delete(); for (int i = 0; i < 16; i++) gw.push_back(32'hA0 + 32'(i));
        run_batch("n16", 16, 0);
        gw.delete(); for (int i = 0; i < 40; i++) gw.push_back($urandom);
        run_batch("n40_stall", 40, 2);
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 50);
            gw.delete(); for (int i = 0; i < n; i++) gw.push_back($urandom);
            run_batch("rand", n, 1);
        end

        // Abort a 40-word batch after 20 words with an async reset.
        gw.delete(); for (int i = 0; i < 40; i++) gw.push_back($urandom);
        @(negedge clk);
        cmd_TVALID = 1'b1; cmd_TDATA = 32'd40;
        @(posedge clk);
        p = 0;
        for (int c = 0; c < 200 && p < 20; c++) begin
            @(negedge clk);
            cmd_TVALID = 1'b0; tx_data_TREADY = 1'b1;
            in_TVALID = 1'b1; in_TDATA = gw[p];
            #1 if (in_TREADY) p++;
            @(posedge clk);
        end
        in_TVALID = 1'b0;
        chk("abort.accepted", p, 20);
        @(negedge clk);
        chk("abort.busy_before", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.tvalid", tx_data_TVALID, 1'b0);
        chk("abort.tdata", tx_data_TDATA, '0);
        chk("abort.tlast", tx_data_TLAST, 1'b0);
        chk("abort.busy", busy, 1'b0);
        chk("abort.in_ready", in_TREADY, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort.no_stale_line", tx_data_TVALID, 1'b0);
        end
        tx_data_TREADY = 1'b0;
        gw.delete(); gw.push_back(32'd7); gw.push_back(32'd8); gw.push_back(32'd9);
        run_batch("post_rst_n3", 3, 0);

        chk("line_count.max", 512'(line_count(32'hFFFFFFFF)), 512'h10000000);
        chk("line_count.15", 512'(line_count(32'd15)), 512'd1);
        chk("line_count.16", 512'(line_count(32'd16)), 512'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
